wb_snapshot_reader: RTL

WB_SNAPSHOT_READER -- requirements
Module: wb_snapshot_reader

---
 rtl/wb_snapshot_reader.sv | 100 ++++++++++
 1 files changed

// File: rtl/wb_snapshot_reader.sv
// wb_snapshot_reader: shadows delayed write-backs and streams a masked, frozen register snapshot over valid/ready
module wb_snapshot_reader #(
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wb_enable_i,
    input  logic [REG_WIDTH-1:0]           wb_reg_i,
    input  logic [DATA_WIDTH-1:0]          wb_data_i,
    input  logic                           snap_req_i,
    input  logic [(1 << REG_WIDTH)-1:0]    snap_mask_i,
    output logic                           snap_busy_o,
    output logic                           out_valid_o,
    output logic [REG_WIDTH-1:0]           out_reg_o,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    input  logic                           out_ready_i,
    output logic                           snap_done_o,
    output logic [REG_WIDTH:0]             snap_count_o
);
    localparam int NREGS = 1 << REG_WIDTH;
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] shadow [NREGS];
    logic [DATA_WIDTH-1:0] snap [NREGS];
    logic [NREGS-1:0]      pending;
    logic [NREGS-1:0]      pending_left;
    logic [REG_WIDTH-1:0]  first_idx;
    logic [REG_WIDTH-1:0]  next_idx;
    logic                  fire;

    function automatic logic [REG_WIDTH-1:0] lowest(input logic [NREGS-1:0] m);
        lowest = '0;
        for (int i = NREGS - 1; i >= 0; i--)
            if (m[i]) lowest = REG_WIDTH'(i);
    endfunction

    always_comb begin
        fire         = out_valid_o & out_ready_i;
        pending_left = pending & ~(NREGS'(1) << out_reg_o);
        first_idx    = lowest(snap_mask_i);
        next_idx     = lowest(pending_left);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            snap_count_o <= '0;
            snap_busy_o  <= 1'b0;
            out_valid_o  <= 1'b0;
            out_reg_o    <= '0;
            out_data_o   <= '0;
            snap_done_o  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                shadow[i] <= '0;
                snap[i]   <= '0;
            end
        end else begin
            if (wb_enable_i) shadow[wb_reg_i] <= wb_data_i;
            snap_done_o <= 1'b0;
            case (state)
                IDLE: if (snap_req_i) begin
                    snap         <= shadow;
                    pending      <= snap_mask_i;
                    snap_count_o <= '0;
                    snap_busy_o  <= 1'b1;
                    if (snap_mask_i != '0) begin
                        state       <= EMIT;
                        out_valid_o <= 1'b1;
                        out_reg_o   <= first_idx;
                        out_data_o  <= shadow[first_idx];
                    end else begin
                        state       <= DONE;
                        snap_done_o <= 1'b1;
                    end
                end
                EMIT: if (fire) begin
                    pending      <= pending_left;
                    snap_count_o <= snap_count_o + (REG_WIDTH+1)'(1);
                    if (pending_left == '0) begin
                        state       <= DONE;
                        out_valid_o <= 1'b0;
                        out_reg_o   <= '0;
                        out_data_o  <= '0;
                        snap_done_o <= 1'b1;
                    end else begin
                        out_reg_o  <= next_idx;
                        out_data_o <= snap[next_idx];
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    snap_busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
